sha256_axil_regfile: RTL and testbench

//   Parametrised AXI4-Lite slave register file for the SHA-256 IP. It replaces the fixed
//   4 x 32-bit slave register bank: register count, data width and per-register

---
 rtl/sha256_axil_regfile_if.sv | 46 ++++
 rtl/sha256_axil_regfile.sv | 202 ++++++++++++++++++++
 tb/tb_sha256_axil_regfile.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_axil_regfile_if.sv
// AXI4-Lite bus bundle for the SHA-256 register file.
// The master modport is the interconnect side; the slave modport is the register file.
interface sha256_axil_regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/sha256_axil_regfile.sv
// Parametrised AXI4-Lite slave register file for the SHA-256 core, with WSTRB and RO mapping.
// Define SHA256_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module sha256_axil_regfile #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 6,
  parameter int unsigned         NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  sha256_axil_regfile_if.slave           s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;

  localparam logic [1:0] RespOkay = 2'b00;
`ifdef SHA256_AXIL_SLVERR_EN
  localparam logic [1:0] RespOor  = 2'b10;
`else
  localparam logic [1:0] RespOor  = 2'b00;
`endif

  typedef enum logic {WrIdle, WrResp} wr_state_e;
  typedef enum logic {RdIdle, RdData} rd_state_e;

  wr_state_e                   wr_state_q, wr_state_d;
  rd_state_e                   rd_state_q, rd_state_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        aw_held_q, aw_held_d;
  logic                        w_held_q, w_held_d;
  logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]           wstrb_q, wstrb_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        arready_q, arready_d;
  logic                        rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d;
  logic [NUM_REGS-1:0]         pulse_q, pulse_d;

  logic                        aw_hs, w_hs, ar_hs;
  logic [31:0]                 wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]       wr_data, rd_val;
  logic [STRB_W-1:0]           wr_strb;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

  assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs  = s_axi.S_AXI_WVALID & wready_q;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;

  // A channel captured on an earlier edge comes from its holding register, else straight off the bus.
  assign wr_idx  = aw_held_q ? 32'(aw_idx_q) : 32'(s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB]);
  assign wr_data = w_held_q ? wdata_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : s_axi.S_AXI_WSTRB;
  assign rd_idx  = 32'(s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:LSB]);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    reg_d      = reg_q;
    pulse_d    = '0;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = WrResp;
          bresp_d    = (wr_idx < NUM_REGS) ? RespOkay : RespOor;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == i && !RO_MASK[i]) begin
              for (int unsigned k = 0; k < STRB_W; k++) begin
                if (wr_strb[k]) reg_d[i*DATA_WIDTH + k*8 +: 8] = wr_data[k*8 +: 8];
              end
              pulse_d[i] = 1'b1;
            end
          end
        end
      end
      WrResp: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WrIdle;
        end
      end
    endcase
    awready_d = (wr_state_d == WrIdle) && !aw_held_d;
    wready_d  = (wr_state_d == WrIdle) && !w_held_d;
  end

  // Reads sample reg_q before this edge's write lands, so a same-edge write is not visible.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == i) begin
        rd_val = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH]
                            : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          rvalid_d   = 1'b1;
          rdata_d    = rd_val;
          rresp_d    = (rd_idx < NUM_REGS) ? RespOkay : RespOor;
          rd_state_d = RdData;
        end
      end
      RdData: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RdIdle;
        end
      end
    endcase
    arready_d = (rd_state_d == RdIdle);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      reg_q      <= '0;
      pulse_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      reg_q      <= reg_d;
      pulse_q    <= pulse_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse        = pulse_q;

endmodule

// File: tb/tb_sha256_axil_regfile.sv
// Directed bench for sha256_axil_regfile: vector table plus skew, backpressure and reset sequences.
// Expected responses follow SHA256_AXIL_SLVERR_EN when it is defined for the build.
module tb_sha256_axil_regfile;

  localparam logic [1:0] OK = 2'b00;
`ifdef SHA256_AXIL_SLVERR_EN
  localparam logic [1:0] SLV = 2'b10;
`else
  localparam logic [1:0] SLV = 2'b00;
`endif

  logic         ACLK;
  logic         ARESET;
  logic [255:0] reg_q;
  logic [255:0] status_i;
  logic [7:0]   reg_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  sha256_axil_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  sha256_axil_regfile #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(6),
    .NUM_REGS  (8),
    .RO_MASK   (8'h80)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_axi       (bus),
    .reg_q       (reg_q),
    .status_i    (status_i),
    .reg_wr_pulse(reg_wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [7:0] pulse,
                           output logic [7:0] pulse_after, output bit ok);
    bit aw_done, w_done, aw_hs, w_hs;
    ok = 1'b0; resp = 2'bxx; pulse = 'x; pulse_after = 'x;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      step();
      if (aw_hs) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hs) begin w_done = 1'b1; bus.S_AXI_WVALID = 1'b0; end
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    if (!(aw_done && w_done)) return;
    for (int i = 0; i < 16 && !bus.S_AXI_BVALID; i++) step();
    if (!bus.S_AXI_BVALID) return;
    resp = bus.S_AXI_BRESP; pulse = reg_wr_pulse;
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_BREADY = 1'b0;
    pulse_after = reg_wr_pulse;
    ok = 1'b1;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit done, hs;
    ok = 1'b0; data = 'x; resp = 2'bxx;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      step();
      if (hs) begin done = 1'b1; bus.S_AXI_ARVALID = 1'b0; end
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!done) return;
    for (int i = 0; i < 16 && !bus.S_AXI_RVALID; i++) step();
    if (!bus.S_AXI_RVALID) return;
    data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    step();
    bus.S_AXI_RREADY = 1'b0;
    ok = 1'b1;
  endtask

  // One write with AW and W separated by three cycles; aw_first picks the leading channel.
  task automatic skew_write(input bit aw_first, input logic [5:0] addr, input logic [31:0] data,
                            input logic [7:0] exp_pulse);
    if (aw_first) begin
      bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    end else begin
      bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    end
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("skew_lead_ready_low", 64'(aw_first ? bus.S_AXI_AWREADY : bus.S_AXI_WREADY), 64'(0));
    check("skew_other_ready_hi", 64'(aw_first ? bus.S_AXI_WREADY : bus.S_AXI_AWREADY), 64'(1));
    repeat (2) step();
    check("skew_no_early_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
    check("skew_no_early_pulse", 64'(reg_wr_pulse), 64'(0));
    if (aw_first) begin
      bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    end else begin
      bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    end
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("skew_bvalid", 64'(bus.S_AXI_BVALID), 64'(1));
    check("skew_pulse", 64'(reg_wr_pulse), 64'(exp_pulse));
    check("skew_awready_resp", 64'(bus.S_AXI_AWREADY), 64'(0));
    step();
    check("skew_bvalid_held", 64'(bus.S_AXI_BVALID), 64'(1));
    check("skew_pulse_once", 64'(reg_wr_pulse), 64'(0));
    check("skew_wready_resp", 64'(bus.S_AXI_WREADY), 64'(0));
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_BREADY = 1'b0;
    check("skew_bvalid_done", 64'(bus.S_AXI_BVALID), 64'(0));
    check("skew_awready_back", 64'(bus.S_AXI_AWREADY), 64'(1));
    check("skew_wready_back", 64'(bus.S_AXI_WREADY), 64'(1));
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
    string       name;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  logic [31:0] exp_regs [8];

  initial begin
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [7:0]  pulse, pulse_after;
    bit          ok;

    vecs[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 32'h0,        OK,  8'h01, "t1_wr0"};
    vecs[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 32'h0,        OK,  8'h02, "t1_wr1"};
    vecs[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 32'h0,        OK,  8'h04, "t1_wr2"};
    vecs[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 32'h0,        OK,  8'h08, "t1_wr3"};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h1,        OK,  8'h00, "t1_rd0"};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h2,        OK,  8'h00, "t1_rd1"};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h3,        OK,  8'h00, "t1_rd2"};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 32'h4,        OK,  8'h00, "t1_rd3"};
    vecs[8]  = '{1'b1, 6'h08, 32'h11223344, 4'hF, 32'h0,        OK,  8'h04, "t2_init"};
    vecs[9]  = '{1'b1, 6'h08, 32'hAABBCCDD, 4'h5, 32'h0,        OK,  8'h04, "t2_strb"};
    vecs[10] = '{1'b0, 6'h08, 32'h0,        4'h0, 32'h11BB33DD, OK,  8'h00, "t2_rd"};
    vecs[11] = '{1'b1, 6'h1C, 32'h0,        4'hF, 32'h0,        OK,  8'h00, "t4_ro_wr"};
    vecs[12] = '{1'b0, 6'h1C, 32'h0,        4'h0, 32'hDEADBEEF, OK,  8'h00, "t4_ro_rd"};
    vecs[13] = '{1'b0, 6'h20, 32'h0,        4'h0, 32'h0,        SLV, 8'h00, "t5_oor_rd"};
    vecs[14] = '{1'b1, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0,        SLV, 8'h00, "t5_oor_wr"};
    vecs[15] = '{1'b1, 6'h10, 32'h12345678, 4'h0, 32'h0,        OK,  8'h10, "strb0_wr"};
    vecs[16] = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h0,        OK,  8'h00, "strb0_rd"};
    vecs[17] = '{1'b0, 6'h05, 32'h0,        4'h0, 32'h2,        OK,  8'h00, "lowbits_rd"};
    vecs[18] = '{1'b0, 6'h18, 32'h0,        4'h0, 32'h0,        OK,  8'h00, "rw_not_status"};
    vecs[19] = '{1'b0, 6'h3F, 32'h0,        4'h0, 32'h0,        SLV, 8'h00, "t5_oor_rd_hi"};
    exp_regs = '{32'h1, 32'h2, 32'h11BB33DD, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0};

    for (int i = 0; i < 8; i++) status_i[i*32 +: 32] = 32'hBAD00000 + 32'(i);
    status_i[7*32 +: 32] = 32'hDEADBEEF;

    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state and release.
    repeat (2) step();
    check("rst_awready", 64'(bus.S_AXI_AWREADY), 64'(0));
    check("rst_arready", 64'(bus.S_AXI_ARREADY), 64'(0));
    check("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
    check("rst_rdata", 64'(bus.S_AXI_RDATA), 64'(0));
    check("rst_regq_zero", 64'(reg_q == '0), 64'(1));
    #2 ARESET = 1'b0;
    #1 check("rel_wready_before_edge", 64'(bus.S_AXI_WREADY), 64'(0));
    step();
    check("rel_awready", 64'(bus.S_AXI_AWREADY), 64'(1));
    check("rel_wready", 64'(bus.S_AXI_WREADY), 64'(1));
    check("rel_arready", 64'(bus.S_AXI_ARREADY), 64'(1));

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse, pulse_after, ok);
        check({vecs[v].name, "_done"}, 64'(ok), 64'(1));
        check({vecs[v].name, "_bresp"}, 64'(resp), 64'(vecs[v].exp_resp));
        check({vecs[v].name, "_pulse"}, 64'(pulse), 64'(vecs[v].exp_pulse));
        check({vecs[v].name, "_pulse_after"}, 64'(pulse_after), 64'(0));
      end else begin
        axi_read(vecs[v].addr, rdata, resp, ok);
        check({vecs[v].name, "_done"}, 64'(ok), 64'(1));
        check({vecs[v].name, "_rresp"}, 64'(resp), 64'(vecs[v].exp_resp));
        check({vecs[v].name, "_rdata"}, 64'(rdata), 64'(vecs[v].exp_data));
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("regq_slice%0d", i), 64'(reg_q[i*32 +: 32]), 64'(exp_regs[i]));
    end

    // Channel skew: AW leading into reg5, then W leading into reg6.
    skew_write(1'b1, 6'h14, 32'h55, 8'h20);
    skew_write(1'b0, 6'h18, 32'h66, 8'h40);
    check("skew_reg5", 64'(reg_q[5*32 +: 32]), 64'h55);
    check("skew_reg6", 64'(reg_q[6*32 +: 32]), 64'h66);

    // Write and read of reg5 on the same edge, then hold both responses under backpressure.
    bus.S_AXI_AWADDR = 6'h14; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 6'h14; bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("same_edge_rdata_old", 64'(bus.S_AXI_RDATA), 64'h55);
    check("same_edge_reg5_new", 64'(reg_q[5*32 +: 32]), 64'h77);
    check("same_edge_pulse", 64'(reg_wr_pulse), 64'h20);
    bus.S_AXI_AWADDR = 6'h00; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_ARADDR = 6'h00; bus.S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_bvalid_c%0d", c), 64'(bus.S_AXI_BVALID), 64'(1));
      check($sformatf("bp_rvalid_c%0d", c), 64'(bus.S_AXI_RVALID), 64'(1));
      check($sformatf("bp_rdata_c%0d", c), 64'(bus.S_AXI_RDATA), 64'h55);
      check($sformatf("bp_awready_c%0d", c), 64'(bus.S_AXI_AWREADY), 64'(0));
      check($sformatf("bp_arready_c%0d", c), 64'(bus.S_AXI_ARREADY), 64'(0));
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    step();
    bus.S_AXI_RREADY = 1'b0;
    check("bp_rvalid_cleared", 64'(bus.S_AXI_RVALID), 64'(0));
    check("bp_arready_back", 64'(bus.S_AXI_ARREADY), 64'(1));
    check("bp_bvalid_still", 64'(bus.S_AXI_BVALID), 64'(1));

    // Reset while the write response is still pending.
    #3 ARESET = 1'b1;
    #1;
    check("midrst_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
    check("midrst_regq_zero", 64'(reg_q == '0), 64'(1));
    check("midrst_awready", 64'(bus.S_AXI_AWREADY), 64'(0));
    step();
    #2 ARESET = 1'b0;
    step();
    check("postrst_awready", 64'(bus.S_AXI_AWREADY), 64'(1));
    check("postrst_wready", 64'(bus.S_AXI_WREADY), 64'(1));
    check("postrst_arready", 64'(bus.S_AXI_ARREADY), 64'(1));
    check("postrst_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));

    axi_write(6'h00, 32'hCAFEF00D, 4'hF, resp, pulse, pulse_after, ok);
    check("postrst_wr_done", 64'(ok), 64'(1));
    check("postrst_wr_pulse", 64'(pulse), 64'h01);
    axi_read(6'h00, rdata, resp, ok);
    check("postrst_rd_done", 64'(ok), 64'(1));
    check("postrst_rd_data", 64'(rdata), 64'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
